// File: rtl/ppu_pkg.sv
// Shared PPU types, constants and palette helper for the pixel pipe.
// PIXEL_PIPE_BG_PRIORITY_EN selects whether sprite slots carry the BG-priority bit.
package ppu_pkg;

   localparam int         FIFO_DEPTH  = 8;
   localparam logic [1:0] TRANSPARENT = 2'b00;

   typedef struct packed {
      logic lcd_en;
      logic win_map;
      logic win_en;
      logic tile_sel;
      logic bg_map;
      logic obj_size;
      logic obj_ena;
      logic bg_ena;
   } lcdc_t;

   typedef struct packed {
      logic [7:0] lo;
      logic [7:0] hi;
      logic       bg_prio;
      logic       y_flip;
      logic       x_flip;
      logic       pal;
   } sprite_data_t;

`ifdef PIXEL_PIPE_BG_PRIORITY_EN
   typedef struct packed {
      logic [1:0] col;
      logic       pal;
      logic       prio;
   } obj_px_t;
`else
   typedef struct packed {
      logic [1:0] col;
      logic       pal;
   } obj_px_t;
`endif

   // Shade for colour c is the 2-bit field pal[2c+1:2c].
   function automatic logic [1:0] pal_lookup(input logic [7:0] pal, input logic [1:0] c);
      return pal[{c, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/sprite_merge_fifo.sv
// Eight-slot sprite pixel FIFO: merges sprite rows into transparent slots, shifts on output.
// PIXEL_PIPE_BG_PRIORITY_EN keeps the BG-priority bit in each slot.
module sprite_merge_fifo
   import ppu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clear,
   input  logic         i_merge,
   input  logic         i_shift,
   input  sprite_data_t i_spr,
   output obj_px_t      o_head
);

   obj_px_t r_slot [FIFO_DEPTH];
   obj_px_t w_new  [FIFO_DEPTH];
   logic    w_unused;

   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         w_new[i]     = '0;
         w_new[i].col = i_spr.x_flip ? {i_spr.hi[i], i_spr.lo[i]}
                                     : {i_spr.hi[FIFO_DEPTH-1-i], i_spr.lo[FIFO_DEPTH-1-i]};
         w_new[i].pal = i_spr.pal;
`ifdef PIXEL_PIPE_BG_PRIORITY_EN
         w_new[i].prio = i_spr.bg_prio;
`endif
      end
   end

   // Earlier sprites own their pixels: only transparent slots accept a new opaque pixel.
   always_ff @(posedge clk) begin
      if (!rst || i_clear) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_slot[i] <= '0;
      end else if (i_merge) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            if (r_slot[i].col == TRANSPARENT && w_new[i].col != TRANSPARENT)
               r_slot[i] <= w_new[i];
      end else if (i_shift) begin
         for (int i = 0; i < FIFO_DEPTH-1; i++) r_slot[i] <= r_slot[i+1];
         r_slot[FIFO_DEPTH-1] <= '0;
      end
   end

   assign o_head = r_slot[0];

`ifdef PIXEL_PIPE_BG_PRIORITY_EN
   assign w_unused = &{1'b0, i_spr.y_flip};
`else
   assign w_unused = &{1'b0, i_spr.y_flip, i_spr.bg_prio};
`endif

endmodule

// File: rtl/pixel_pipe.sv
// BG/sprite pixel FIFOs with fine-scroll discard, BG/OBJ mixer and palette mapping to LCD.
// PIXEL_PIPE_BG_PRIORITY_EN: honour sprite bg_prio against opaque BG pixels.
module pixel_pipe
   import ppu_pkg::*;
#(
   parameter int LINE_WIDTH = 160
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic       line_start,
   input  logic [7:0] scx,
   input  logic       bg_push,
   input  logic [7:0] bg_lo,
   input  logic [7:0] bg_hi,
   output logic       bg_ready,
   input  logic       bg_flush,
   input  logic       spr_push,
   input  logic [7:0] spr_lo,
   input  logic [7:0] spr_hi,
   input  logic [3:0] spr_attrs,
   input  logic       stall,
   input  logic [7:0] lcdc,
   input  logic [7:0] bgp,
   input  logic [7:0] obp0,
   input  logic [7:0] obp1,
   output logic       pix_valid,
   output logic [1:0] pix_shade,
   output logic [7:0] pix_x,
   output logic       line_done
);

   logic [1:0]   r_bg [FIFO_DEPTH];
   logic [3:0]   r_count;
   logic [2:0]   r_discard;
   logic [7:0]   r_x;
   logic         r_done;

   lcdc_t        w_lcdc;
   sprite_data_t w_spr;
   obj_px_t      w_obj;
   logic         w_bg_load, w_merge, w_pop, w_discard, w_emit, w_last, w_use_spr;
   logic [1:0]   w_bgc, w_shade;
   logic         w_unused;

   assign w_lcdc = lcdc_t'(lcdc);

   always_comb begin
      w_spr         = '0;
      w_spr.lo      = spr_lo;
      w_spr.hi      = spr_hi;
      w_spr.bg_prio = spr_attrs[3];
      w_spr.y_flip  = spr_attrs[2];
      w_spr.x_flip  = spr_attrs[1];
      w_spr.pal     = spr_attrs[0];
   end

   // line_start outranks every other request; bg_flush outranks bg_push.
   assign bg_ready  = (r_count == 4'd0) && !r_done;
   assign w_bg_load = ce && bg_push && bg_ready && !line_start && !bg_flush;
   assign w_merge   = ce && spr_push && !r_done && !line_start;
   assign w_pop     = ce && (r_count != 4'd0) && !stall && !spr_push && !r_done
                      && !line_start && !bg_flush;
   assign w_discard = w_pop && (r_discard != 3'd0);
   assign w_emit    = w_pop && (r_discard == 3'd0);
   assign w_last    = (r_x == 8'(LINE_WIDTH - 1));

   assign w_bgc = w_lcdc.bg_ena ? r_bg[0] : TRANSPARENT;
`ifdef PIXEL_PIPE_BG_PRIORITY_EN
   assign w_use_spr = w_lcdc.obj_ena && (w_obj.col != TRANSPARENT)
                      && !(w_obj.prio && (w_bgc != TRANSPARENT));
`else
   assign w_use_spr = w_lcdc.obj_ena && (w_obj.col != TRANSPARENT);
`endif
   assign w_shade = w_use_spr ? pal_lookup(w_obj.pal ? obp1 : obp0, w_obj.col)
                              : pal_lookup(bgp, w_bgc);

   sprite_merge_fifo u_spr_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clear (ce && line_start),
      .i_merge (w_merge),
      .i_shift (w_emit),
      .i_spr   (w_spr),
      .o_head  (w_obj)
   );

   always_ff @(posedge clk) begin
      if (w_bg_load) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_bg[i] <= {bg_hi[FIFO_DEPTH-1-i], bg_lo[FIFO_DEPTH-1-i]};
      end else if (w_pop) begin
         for (int i = 0; i < FIFO_DEPTH-1; i++) r_bg[i] <= r_bg[i+1];
         r_bg[FIFO_DEPTH-1] <= TRANSPARENT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count   <= 4'd0;
         r_discard <= 3'd0;
         r_x       <= 8'd0;
         r_done    <= 1'b1;
         pix_valid <= 1'b0;
         pix_shade <= 2'd0;
         pix_x     <= 8'd0;
         line_done <= 1'b0;
      end else if (ce) begin
         pix_valid <= w_emit;
         line_done <= w_emit && w_last;
         if (w_emit) begin
            pix_shade <= w_shade;
            pix_x     <= r_x;
         end
         if (line_start) begin
            r_count   <= 4'd0;
            r_discard <= scx[2:0];
            r_x       <= 8'd0;
            r_done    <= 1'b0;
         end else begin
            if (bg_flush)       r_count <= 4'd0;
            else if (w_bg_load) r_count <= 4'd8;
            else if (w_pop)     r_count <= r_count - 4'd1;
            if (w_discard) r_discard <= r_discard - 3'd1;
            // x saturates on the last pixel; done then idles the pipe until line_start.
            if (w_emit) begin
               if (w_last) r_done <= 1'b1;
               else        r_x    <= r_x + 8'd1;
            end
         end
      end
   end

   assign w_unused = &{1'b0, scx[7:3], w_lcdc.lcd_en, w_lcdc.win_map, w_lcdc.win_en,
                       w_lcdc.tile_sel, w_lcdc.bg_map, w_lcdc.obj_size};

endmodule

// File: tb/tb_pixel_pipe.sv
// Directed scoreboard bench for pixel_pipe: expected pixels queued at stimulus, checked on output.
module tb_pixel_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ce = 1'b1;
   logic       line_start = 1'b0;
   logic [7:0] scx = 8'd0;
   logic       bg_push = 1'b0;
   logic [7:0] bg_lo = 8'd0;
   logic [7:0] bg_hi = 8'd0;
   logic       bg_ready;
   logic       bg_flush = 1'b0;
   logic       spr_push = 1'b0;
   logic [7:0] spr_lo = 8'd0;
   logic [7:0] spr_hi = 8'd0;
   logic [3:0] spr_attrs = 4'd0;
   logic       stall = 1'b0;
   logic [7:0] lcdc = 8'h03;
   logic [7:0] bgp = 8'hE4;
   logic [7:0] obp0 = 8'hFF;
   logic [7:0] obp1 = 8'h1B;
   logic       pix_valid;
   logic [1:0] pix_shade;
   logic [7:0] pix_x;
   logic       line_done;

   pixel_pipe #(.LINE_WIDTH(160)) dut (
      .clk(clk), .rst(rst), .ce(ce), .line_start(line_start), .scx(scx),
      .bg_push(bg_push), .bg_lo(bg_lo), .bg_hi(bg_hi), .bg_ready(bg_ready),
      .bg_flush(bg_flush), .spr_push(spr_push), .spr_lo(spr_lo), .spr_hi(spr_hi),
      .spr_attrs(spr_attrs), .stall(stall), .lcdc(lcdc), .bgp(bgp), .obp0(obp0),
      .obp1(obp1), .pix_valid(pix_valid), .pix_shade(pix_shade), .pix_x(pix_x),
      .line_done(line_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int shade;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   ld_cnt   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_line_start(input logic [7:0] s);
      scx        = s;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic push_bg(input logic [7:0] lo, input logic [7:0] hi);
      int n = 0;
      while (!bg_ready && n < 40) begin
         tick();
         n++;
      end
      chk("bg_ready_wait", bg_ready, 1);
      bg_lo   = lo;
      bg_hi   = hi;
      bg_push = 1'b1;
      tick();
      bg_push = 1'b0;
   endtask

   task automatic push_spr(input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] at);
      spr_lo    = lo;
      spr_hi    = hi;
      spr_attrs = at;
      spr_push  = 1'b1;
      tick();
      spr_push  = 1'b0;
   endtask

   // Pixel i of the group takes its shade from sh[15-2i -: 2] (leftmost pixel in the top bits).
   task automatic exp_px(input int x0, input int n, input logic [15:0] sh);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.x     = x0 + i;
         e.shade = int'(sh[15-2*i -: 2]);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (pix_valid) begin
         chk("pix_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            chk("pix_x", pix_x, m_e.x);
            chk("pix_shade", pix_shade, m_e.shade);
            chk("line_done_at_x", line_done, (m_e.x == 159));
         end
      end else if (line_done) begin
         chk("line_done_alone", pix_valid, 1);
      end
      if (line_done) ld_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_shade", pix_shade, 0);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_bg_ready", bg_ready, 0);
      rst = 1'b1;
      tick();
      chk("idle_not_ready", bg_ready, 0);

      // Plain BG line, latency and stall
      do_line_start(8'd0);
      exp_px(0, 8, 16'h5555);
      push_bg(8'hFF, 8'h00);
      chk("latency_load_cycle", pix_valid, 0);
      tick();
      chk("latency_valid", pix_valid, 1);
      chk("latency_x", pix_x, 0);
      stall = 1'b1;
      tick();
      chk("stall_holds", pix_valid, 0);
      tick();
      stall = 1'b0;
      wait_drain(20);

      // Fine scroll discards three pixels
      do_line_start(8'd3);
      exp_px(0, 5, 16'h6AA0);
      push_bg(8'hF0, 8'h0F);
      wait_drain(20);

      // Sprite over transparent BG with OBP1
      bgp = 8'hE5;
      do_line_start(8'd0);
      push_spr(8'h80, 8'h80, 4'b0001);
      exp_px(0, 8, 16'h1555);
      push_bg(8'h00, 8'h00);
      wait_drain(20);

      // Two sprites on the same x: earlier one keeps slot 7
      do_line_start(8'd0);
      push_spr(8'h01, 8'h00, 4'b0000);
      push_spr(8'hFF, 8'h00, 4'b0001);
      exp_px(0, 8, 16'hAAAB);
      push_bg(8'h00, 8'h00);
      wait_drain(20);

      // x_flip takes bit i for slot i
      do_line_start(8'd0);
      push_spr(8'h01, 8'h00, 4'b0010);
      exp_px(0, 8, 16'hD555);
      push_bg(8'h00, 8'h00);
      wait_drain(20);

      // BG priority against opaque and transparent BG
      bgp = 8'hE4;
      do_line_start(8'd0);
      push_spr(8'h00, 8'hFF, 4'b1000);
`ifdef PIXEL_PIPE_BG_PRIORITY_EN
      exp_px(0, 8, 16'h5555);
`else
      exp_px(0, 8, 16'hFFFF);
`endif
      push_bg(8'hFF, 8'h00);
      wait_drain(20);
      do_line_start(8'd0);
      push_spr(8'h00, 8'hFF, 4'b1000);
`ifdef PIXEL_PIPE_BG_PRIORITY_EN
      exp_px(0, 8, 16'h55FF);
`else
      exp_px(0, 8, 16'hFFFF);
`endif
      push_bg(8'hF0, 8'h00);
      wait_drain(20);

      // BG disabled forces colour 0
      lcdc = 8'h02;
      bgp  = 8'hE6;
      do_line_start(8'd0);
      exp_px(0, 8, 16'hAAAA);
      push_bg(8'hFF, 8'h00);
      wait_drain(20);
      lcdc = 8'h03;
      bgp  = 8'hE4;

      // Full line of 160 pixels
      ld_cnt = 0;
      do_line_start(8'd0);
      for (int k = 0; k < 20; k++) begin
         exp_px(8 * k, 8, 16'h5555);
         push_bg(8'hFF, 8'h00);
      end
      wait_drain(40);
      chk("line_done_count", ld_cnt, 1);
      chk("ready_after_done", bg_ready, 0);
      bg_lo   = 8'hFF;
      bg_push = 1'b1;
      repeat (5) tick();
      bg_push = 1'b0;
      chk("done_push_ignored", pix_valid, 0);
      chk("done_still_not_ready", bg_ready, 0);
      chk("x_saturated", pix_x, 159);

      // Mid-line reset
      do_line_start(8'd0);
      chk("ready_new_line", bg_ready, 1);
      exp_px(0, 8, 16'h5555);
      push_bg(8'hFF, 8'h00);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("pre_reset_remaining", exp_q.size(), 6);
      exp_q.delete();
      chk("midrst_pix_valid", pix_valid, 0);
      chk("midrst_pix_x", pix_x, 0);
      chk("midrst_line_done", line_done, 0);
      chk("midrst_bg_ready", bg_ready, 0);
      rst = 1'b1;
      tick();
      chk("midrst_no_line_done", ld_cnt, 1);
      chk("midrst_idle", bg_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
